// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter and its requester-side clients.
package arb_pkg;

  // Default number of requester channels seen by the arbiter and its clients.
  localparam int N_REQ_DEF = 4;

  // Helpers take vectors zero-extended to this width, so one function serves any N_REQ up to 32.
  localparam int MAX_REQ   = 32;
  localparam int MAX_IDX_W = $clog2(MAX_REQ);

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic is_onehot(input logic [MAX_REQ-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_REQ'(1))) == '0);
  endfunction

  // Binary index of a one-hot vector. The OR-reduction keeps this a plain encoder; the result is
  // meaningless unless the input is one-hot.
  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (vec[i]) begin
        idx = idx | MAX_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/req_chan_cnt.sv
// Saturating pending-item counter for one requester channel.
// A push and a take in the same cycle cancel out, so a full channel can accept a push while one
// item is being retired without reporting an overflow.
module req_chan_cnt
  import arb_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_take,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_nonzero,
  output logic             o_full,
  output logic             o_ovf
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0] r_cnt;
  logic             w_atMax;
  logic             w_atZero;

  assign w_atMax  = (r_cnt == MAX_CNT);
  assign w_atZero = (r_cnt == '0);

  // Count pushes up and takes down, saturating at both ends so the counter never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_push && !i_take && !w_atMax) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_take && !i_push && !w_atZero) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_nonzero = !w_atZero;
  assign o_full    = w_atMax;
  assign o_ovf     = i_push && !i_take && w_atMax;

endmodule

// File: rtl/arb_req_client.sv
// Requester-side companion to the round-robin arbiter. It keeps a pending count per channel, raises
// requests, retires one item per legal grant, reports the issued channel a cycle later and keeps
// sticky flags for overflow and illegal grants.
module arb_req_client
  import arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int DEPTH = 3,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] push_i,
  input  logic [N_REQ-1:0] gnt_i,
  output logic [N_REQ-1:0] req_o,
  output logic [N_REQ-1:0] full_o,
  output logic             issue_valid_o,
  output logic [ID_W-1:0]  issue_id_o,
  output logic             err_ovf_o,
  output logic             err_gnt_o
);

  logic [CNT_W-1:0] w_cnt [N_REQ];
  logic [N_REQ-1:0] w_nonzero;
  logic [N_REQ-1:0] w_ovf;
  logic [N_REQ-1:0] w_take;
  logic             w_onehot;
  logic             w_gntValid;
  logic             w_gntIllegal;
  logic [ID_W-1:0]  w_gntIdx;

  logic             r_issueValid;
  logic [ID_W-1:0]  r_issueId;
  logic             r_errOvf;
  logic             r_errGnt;

  // A grant is honoured only when it is one-hot and lands on a channel with pending work; any other
  // non-zero grant is dropped entirely and flagged.
  assign w_onehot     = is_onehot(MAX_REQ'(gnt_i));
  assign w_gntValid   = w_onehot && ((gnt_i & w_nonzero) != '0);
  assign w_gntIllegal = (gnt_i != '0) && !w_gntValid;
  assign w_take       = w_gntValid ? gnt_i : '0;
  assign w_gntIdx     = ID_W'(onehot2idx(MAX_REQ'(gnt_i)));

  // The request hides the item being retired this cycle so the arbiter, which registers its grant,
  // never re-grants a channel that is draining to zero. The grant comes from a register, so there is
  // no combinational loop through the arbiter.
  for (genvar g = 0; g < N_REQ; g++) begin : gen_chan
    req_chan_cnt #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_push    (push_i[g]),
      .i_take    (w_take[g]),
      .o_cnt     (w_cnt[g]),
      .o_nonzero (w_nonzero[g]),
      .o_full    (full_o[g]),
      .o_ovf     (w_ovf[g])
    );

    assign req_o[g] = (w_cnt[g] - CNT_W'(w_take[g])) != '0;
  end

  // Report an accepted grant one cycle later; the id holds its last value between issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_issueValid <= 1'b0;
      r_issueId    <= '0;
    end else begin
      r_issueValid <= w_gntValid;
      if (w_gntValid) begin
        r_issueId <= w_gntIdx;
      end
    end
  end

  // Sticky protocol-violation flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_errOvf <= 1'b0;
      r_errGnt <= 1'b0;
    end else begin
      if (w_ovf != '0) begin
        r_errOvf <= 1'b1;
      end
      if (w_gntIllegal) begin
        r_errGnt <= 1'b1;
      end
    end
  end

  assign issue_valid_o = r_issueValid;
  assign issue_id_o    = r_issueId;
  assign err_ovf_o     = r_errOvf;
  assign err_gnt_o     = r_errGnt;

endmodule
